// File: rtl/chnl_pkg.sv
// chnl_pkg: shared widths and types for the channel responder slice.
package chnl_pkg;
    localparam int DATA_W = 32;
    localparam int MARGIN_W = 5;
    typedef logic [DATA_W-1:0] chnl_data_t;
    typedef logic [15:0] chnl_cnt_t;
endpackage

// File: rtl/chnl_if.sv
// chnl_if: initiator-side and downstream-side handshake bundle of the responder.
interface chnl_if import chnl_pkg::*; #(parameter int DATA_W = chnl_pkg::DATA_W);
    logic [DATA_W-1:0]   ch_data;
    logic                ch_valid;
    logic                ch_ready;
    logic [MARGIN_W-1:0] ch_margin;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    modport master (
        output ch_data, ch_valid, out_ready,
        input  ch_ready, ch_margin, out_data, out_valid
    );
    modport slave (
        input  ch_data, ch_valid, out_ready,
        output ch_ready, ch_margin, out_data, out_valid
    );
endinterface

// File: rtl/chnl_fifo.sv
// chnl_fifo: first-word fall-through FIFO with occupancy-based full/empty and free-slot margin.
module chnl_fifo import chnl_pkg::*; #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = chnl_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                full,
    output logic                empty,
    output logic [MARGIN_W-1:0] margin
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       occ;
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push != pop) occ <= push ? occ + (AW+1)'(1) : occ - (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
    // Storage is never reset, so the head is masked to zero whenever nothing valid is held.
    assign full   = occ == (AW+1)'(DEPTH);
    assign empty  = occ == '0;
    assign rdata  = empty ? '0 : mem[rd_ptr];
    assign margin = MARGIN_W'(DEPTH) - MARGIN_W'(occ);
endmodule

// File: rtl/chnl_responder.sv
// chnl_responder: accepts channel words into a FIFO, forwards them downstream, and keeps accept/stall statistics.
module chnl_responder import chnl_pkg::*; #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = chnl_pkg::DATA_W
) (
    input  logic      clk,
    input  logic      rstn,
    chnl_if.slave     ch,
    input  logic      clr_stats,
    output chnl_cnt_t rx_count,
    output chnl_cnt_t stall_count
);
    logic push, pop, full, empty;
    assign push         = ch.ch_valid && ch.ch_ready;
    assign pop          = ch.out_valid && ch.out_ready;
    assign ch.ch_ready  = !full;
    assign ch.out_valid = !empty;
    chnl_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push   (push),
        .pop    (pop),
        .wdata  (ch.ch_data),
        .rdata  (ch.out_data),
        .full   (full),
        .empty  (empty),
        .margin (ch.ch_margin)
    );
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rx_count    <= '0;
            stall_count <= '0;
        end else if (clr_stats) begin
            rx_count    <= '0;
            stall_count <= '0;
        end else begin
            if (push) rx_count <= rx_count + chnl_cnt_t'(1);
            if (ch.ch_valid && !ch.ch_ready && stall_count != '1) stall_count <= stall_count + chnl_cnt_t'(1);
        end
    end
endmodule

// File: tb/tb_chnl_responder.sv
// tb_chnl_responder: directed stimulus with a scoreboard queue checked by an independent output monitor.
module tb_chnl_responder;
    import chnl_pkg::*;
    logic clk, rstn, clr_stats;
    chnl_cnt_t rx_count, stall_count;
    chnl_data_t exp_q[$];
    int cmp_n = 0;
    int err_n = 0;
    chnl_if #(.DATA_W(32)) bus ();
    chnl_responder #(.DEPTH(16), .DATA_W(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ch          (bus),
        .clr_stats   (clr_stats),
        .rx_count    (rx_count),
        .stall_count (stall_count)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Output monitor: a pop happens at the next rising edge whenever valid and ready are both high now.
    always @(negedge clk) begin
        if (!rstn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                cmp_n++;
                err_n++;
                $display("FAIL unexpected_pop: got %0h expected none", bus.out_data);
            end else begin
                chk("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end
    task automatic send(input chnl_data_t w);
        bus.ch_valid = 1;
        bus.ch_data  = w;
        exp_q.push_back(w);
        tick();
    endtask
    initial begin
        rstn = 1; clr_stats = 0;
        bus.ch_valid = 0; bus.ch_data = 'x; bus.out_ready = 0;
        repeat (10) tick();
        chk("rst_ready", bus.ch_ready, 1);
        chk("rst_margin", bus.ch_margin, 16);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        rstn = 0;
        tick();
        chk("post_rst_ready", bus.ch_ready, 1);
        chk("post_rst_margin", bus.ch_margin, 16);
        chk("post_rst_rx", rx_count, 0);
        chk("post_rst_stall", stall_count, 0);
        send(32'hDEADBEEF);
        bus.ch_valid = 0; bus.ch_data = 'x;
        chk("single_valid", bus.out_valid, 1);
        chk("single_data", bus.out_data, 32'hDEADBEEF);
        chk("single_margin", bus.ch_margin, 15);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        chk("single_drained", bus.out_valid, 0);
        chk("single_margin2", bus.ch_margin, 16);
        chk("single_rx", rx_count, 1);
        clr_stats = 1;
        tick();
        clr_stats = 0;
        chk("clr_rx", rx_count, 0);
        for (int i = 0; i < 16; i++) send(chnl_data_t'(i));
        bus.ch_data = 32'h10;
        chk("full_ready", bus.ch_ready, 0);
        chk("full_margin", bus.ch_margin, 0);
        repeat (5) tick();
        chk("full_stall", stall_count, 5);
        chk("full_rx", rx_count, 16);
        exp_q.push_back(32'h10);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        chk("pop_full_ready", bus.ch_ready, 1);
        chk("pop_full_margin", bus.ch_margin, 1);
        tick();
        bus.ch_valid = 0; bus.ch_data = 'x;
        chk("refill_margin", bus.ch_margin, 0);
        chk("refill_rx", rx_count, 17);
        chk("refill_stall", stall_count, 6);
        bus.out_ready = 1;
        repeat (16) tick();
        bus.out_ready = 0;
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_margin", bus.ch_margin, 16);
        chk("drain_queue", exp_q.size(), 0);
        clr_stats = 1;
        tick();
        clr_stats = 0;
        bus.out_ready = 1;
        for (int i = 0; i < 100; i++) begin
            send($urandom);
            chk("stream_margin", 32'(bus.ch_margin >= 15), 1);
        end
        bus.ch_valid = 0; bus.ch_data = 'x;
        tick();
        bus.out_ready = 0;
        chk("stream_rx", rx_count, 100);
        chk("stream_empty", bus.out_valid, 0);
        chk("stream_queue", exp_q.size(), 0);
        for (int i = 0; i < 5; i++) send(chnl_data_t'(32'hA0 + i));
        bus.ch_valid = 0; bus.ch_data = 'x;
        chk("pre_rst_margin", bus.ch_margin, 11);
        rstn = 1;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_margin", bus.ch_margin, 16);
        exp_q.delete();
        tick();
        rstn = 0;
        tick();
        send(32'h111);
        send(32'h222);
        clr_stats = 1;
        send(32'h333);
        clr_stats = 0;
        bus.ch_valid = 0; bus.ch_data = 'x;
        chk("clr_prio_rx", rx_count, 0);
        chk("clr_margin", bus.ch_margin, 13);
        chk("clr_head", bus.out_data, 32'h111);
        bus.out_ready = 1;
        repeat (3) tick();
        bus.out_ready = 0;
        chk("final_valid", bus.out_valid, 0);
        chk("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
